// File: rtl/apb_uart_rx_if.sv
// APB register-bus bundle for the UART receiver.
// Handshake: an access is a setup cycle (S_PSELx=1, S_PENABLE=0) followed by an
// access cycle (S_PSELx=1, S_PENABLE=1). The slave is always ready, so the
// transfer completes on the rising edge that ends the access cycle.
// S_PRDATA is only meaningful in the access cycle of a read.
interface apb_uart_rx_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  S_PADDR;
    logic                  S_PWRITE;
    logic                  S_PSELx;
    logic                  S_PENABLE;
    logic [DATA_WIDTH-1:0] S_PWDATA;
    logic [DATA_WIDTH-1:0] S_PRDATA;
    logic                  S_PREADY;

    modport master (
        output S_PADDR, S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA,
        input  S_PRDATA, S_PREADY
    );

    modport slave (
        input  S_PADDR, S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA,
        output S_PRDATA, S_PREADY
    );
endinterface

// File: rtl/apb_uart_rx.sv
// APB UART receiver: 8N1 deserialiser feeding a byte FIFO, with DATA (addr 0)
// and STATUS (addr 1) registers and a level interrupt while bytes are pending.
// STATUS layout: [0] not empty, [1] full, [2] OVR, [3] FERR, [15:8] count.
// DATA_WIDTH must be at least 16 so the count field fits.
module apb_uart_rx #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    apb_uart_rx_if.slave          apb,
    input  logic                  rx_wire,
    output logic                  irq,
    output logic [DATA_WIDTH-1:0] int_data,
    output logic [2:0]            rx_state
);
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam int AW           = $clog2(FIFO_DEPTH);
    localparam int CNTW         = AW + 1;
    localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

    rx_state_t       state;
    logic [CW-1:0]   clk_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift_reg;
    logic            sync1;
    logic            rx_s;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CNTW-1:0] count;
    logic            ovr;
    logic            ferr;

    logic empty, full, access, rd_en, pop, push, push_ok;
    logic frame_done, ovr_set, ovr_clr, ferr_set, ferr_clr;
    logic [DATA_WIDTH-1:0] status;
    logic [DATA_WIDTH-1:0] head;
    logic unused_wdata;

    assign unused_wdata = ^{apb.S_PWDATA[DATA_WIDTH-1:4], apb.S_PWDATA[1:0]};

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx_wire;
            rx_s  <= sync1;
        end
    end

    // Receive FSM: half-bit start qualification, then one sample per bit period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            clk_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state   <= ST_START;
                        clk_cnt <= '0;
                    end
                end
                ST_START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt   <= '0;
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        if (bit_cnt == 3'd7) state <= ST_STOP;
                        else                 bit_cnt <= bit_cnt + 1'b1;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        state   <= rx_s ? ST_IDLE : ST_BREAK;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (rx_s) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign rx_state   = state;
    assign frame_done = (state == ST_STOP) && (clk_cnt == BIT_LAST);
    assign push       = frame_done && rx_s;
    assign ferr_set   = frame_done && !rx_s;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign access  = apb.S_PSELx && apb.S_PENABLE;
    assign rd_en   = access && !apb.S_PWRITE;
    assign pop     = rd_en && !apb.S_PADDR && !empty;
    // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
    assign push_ok = push && (!full || pop);
    assign ovr_set = push && full && !pop;
    assign ovr_clr = access && apb.S_PWRITE && apb.S_PADDR && apb.S_PWDATA[2];
    assign ferr_clr = access && apb.S_PWRITE && apb.S_PADDR && apb.S_PWDATA[3];

    // FIFO storage needs no reset; pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= shift_reg;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags; a set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovr  <= 1'b0;
            ferr <= 1'b0;
        end else begin
            ovr  <= ovr_set  || (ovr  && !ovr_clr);
            ferr <= ferr_set || (ferr && !ferr_clr);
        end
    end

    // Register views and read mux; read data is forced to zero outside read access.
    always_comb begin
        status       = '0;
        status[0]    = !empty;
        status[1]    = full;
        status[2]    = ovr;
        status[3]    = ferr;
        status[15:8] = 8'(count);
        head         = '0;
        if (!empty) head[7:0] = mem[rd_ptr];
        apb.S_PRDATA = '0;
        if (reset && rd_en) apb.S_PRDATA = apb.S_PADDR ? status : head;
    end

    assign apb.S_PREADY = reset && access;
    assign irq          = !empty;
    assign int_data     = status;
endmodule

// File: tb/tb_apb_uart_rx.sv
// Directed bench for apb_uart_rx at 10 clocks per bit and a 4-entry FIFO.
module tb_apb_uart_rx;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          rx_wire = 1'b1;
    logic          irq;
    logic [DW-1:0] int_data;
    logic [2:0]    rx_state;

    int tests = 0;
    int failed = 0;

    apb_uart_rx_if #(.DATA_WIDTH(DW)) bus ();

    apb_uart_rx #(
        .CLK_HZ(1_000_000), .BAUD(100_000), .FIFO_DEPTH(4), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .reset(reset), .apb(bus), .rx_wire(rx_wire),
        .irq(irq), .int_data(int_data), .rx_state(rx_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", tests + 1, failed + 1);
        $fatal(1, "timeout");
    end

    typedef struct {
        int          phase;
        logic        wr;
        logic        addr;
        logic [15:0] wdata;
        logic [15:0] exp;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    function automatic void add(input int ph, input logic wr, input logic addr,
                                input logic [15:0] wd, input logic [15:0] exp, input logic ei);
        vec_t v;
        v.phase = ph; v.wr = wr; v.addr = addr; v.wdata = wd; v.exp = exp; v.exp_irq = ei;
        vecs.push_back(v);
    endfunction

    // Driver tasks: all start on a falling edge and return on a falling edge.
    task automatic apb_read(input logic addr, output logic [15:0] data);
        bus.S_PSELx = 1'b1; bus.S_PENABLE = 1'b0; bus.S_PWRITE = 1'b0; bus.S_PADDR = addr;
        #1;
        check("rd_setup_pready", {15'd0, bus.S_PREADY}, 16'd0);
        check("rd_setup_prdata", bus.S_PRDATA, 16'd0);
        @(negedge clk);
        bus.S_PENABLE = 1'b1;
        #1;
        check("rd_access_pready", {15'd0, bus.S_PREADY}, 16'd1);
        data = bus.S_PRDATA;
        @(negedge clk);
        bus.S_PSELx = 1'b0; bus.S_PENABLE = 1'b0;
    endtask

    task automatic apb_write(input logic addr, input logic [15:0] wdata);
        bus.S_PSELx = 1'b1; bus.S_PENABLE = 1'b0; bus.S_PWRITE = 1'b1;
        bus.S_PADDR = addr; bus.S_PWDATA = wdata;
        @(negedge clk);
        bus.S_PENABLE = 1'b1;
        #1;
        check("wr_access_pready", {15'd0, bus.S_PREADY}, 16'd1);
        check("wr_access_prdata", bus.S_PRDATA, 16'd0);
        @(negedge clk);
        bus.S_PSELx = 1'b0; bus.S_PENABLE = 1'b0; bus.S_PWRITE = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx_wire = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_wire = b[i];
            repeat (10) @(negedge clk);
        end
        rx_wire = stop_bit;
        repeat (10) @(negedge clk);
    endtask

    task automatic run_phase(input int ph);
        logic [15:0] rd;
        foreach (vecs[i]) begin
            if (vecs[i].phase == ph) begin
                @(negedge clk);
                if (vecs[i].wr) begin
                    apb_write(vecs[i].addr, vecs[i].wdata);
                end else begin
                    apb_read(vecs[i].addr, rd);
                    check($sformatf("p%0d_v%0d_%s", ph, i, vecs[i].addr ? "status" : "data"),
                          rd, vecs[i].exp);
                end
                #1;
                check($sformatf("p%0d_v%0d_irq", ph, i), {15'd0, irq}, {15'd0, vecs[i].exp_irq});
                if (!vecs[i].wr && vecs[i].addr)
                    check($sformatf("p%0d_v%0d_int_data", ph, i), int_data, vecs[i].exp);
            end
        end
    endtask

    // Scoreboard stimulus and report
    initial begin
        logic [15:0] rd;

        // phase 1: single 0xA5 frame
        add(1, 0, 1, 16'h0000, 16'h0101, 1);
        add(1, 0, 0, 16'h0000, 16'h00A5, 0);
        add(1, 0, 1, 16'h0000, 16'h0000, 0);
        add(1, 1, 0, 16'hFFFF, 16'h0000, 0);
        add(1, 0, 1, 16'h0000, 16'h0000, 0);
        // phase 2: five frames into a 4-deep FIFO
        add(2, 0, 1, 16'h0000, 16'h0407, 1);
        add(2, 1, 0, 16'h1234, 16'h0000, 1);
        add(2, 0, 1, 16'h0000, 16'h0407, 1);
        add(2, 0, 0, 16'h0000, 16'h0001, 1);
        add(2, 0, 1, 16'h0000, 16'h0305, 1);
        add(2, 0, 0, 16'h0000, 16'h0002, 1);
        add(2, 0, 0, 16'h0000, 16'h0003, 1);
        add(2, 0, 0, 16'h0000, 16'h0004, 0);
        add(2, 0, 0, 16'h0000, 16'h0000, 0);
        add(2, 0, 1, 16'h0000, 16'h0004, 0);
        add(2, 1, 1, 16'hFFF3, 16'h0000, 0);
        add(2, 0, 1, 16'h0000, 16'h0004, 0);
        add(2, 1, 1, 16'h0004, 16'h0000, 0);
        add(2, 0, 1, 16'h0000, 16'h0000, 0);
        // phase 3: clear collides with a new overrun
        add(3, 0, 1, 16'h0000, 16'h0407, 1);
        add(3, 0, 0, 16'h0000, 16'h0010, 1);
        add(3, 0, 0, 16'h0000, 16'h0020, 1);
        add(3, 0, 0, 16'h0000, 16'h0030, 1);
        add(3, 0, 0, 16'h0000, 16'h0040, 0);
        add(3, 0, 1, 16'h0000, 16'h0004, 0);
        add(3, 1, 1, 16'h0004, 16'h0000, 0);
        add(3, 0, 1, 16'h0000, 16'h0000, 0);
        // phase 4: after framing error and break
        add(4, 0, 1, 16'h0000, 16'h0008, 0);
        add(4, 0, 0, 16'h0000, 16'h0000, 0);
        // phase 5: recovery frame 0x55
        add(5, 0, 1, 16'h0000, 16'h0109, 1);
        add(5, 0, 0, 16'h0000, 16'h0055, 0);
        add(5, 1, 1, 16'h0008, 16'h0000, 0);
        add(5, 0, 1, 16'h0000, 16'h0000, 0);
        // phase 6: after an idle-line glitch
        add(6, 0, 1, 16'h0000, 16'h0000, 0);
        // phase 7: frame after mid-frame reset
        add(7, 0, 1, 16'h0000, 16'h0101, 1);
        add(7, 0, 0, 16'h0000, 16'h0066, 0);
        add(7, 0, 1, 16'h0000, 16'h0000, 0);

        // Reset with an APB access held active
        bus.S_PSELx = 1'b1; bus.S_PENABLE = 1'b1; bus.S_PWRITE = 1'b0;
        bus.S_PADDR = 1'b1; bus.S_PWDATA = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_pready", {15'd0, bus.S_PREADY}, 16'd0);
        check("reset_prdata", bus.S_PRDATA, 16'd0);
        check("reset_irq", {15'd0, irq}, 16'd0);
        check("reset_state", {13'd0, rx_state}, 16'd0);
        check("reset_int_data", int_data, 16'd0);
        bus.S_PSELx = 1'b0; bus.S_PENABLE = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // Single frame with exact visibility latency
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (97) @(negedge clk);
                #1;
                check("latency_irq_before", {15'd0, irq}, 16'd0);
                @(negedge clk);
                #1;
                check("latency_irq_after", {15'd0, irq}, 16'd1);
            end
        join
        run_phase(1);

        // Back-to-back frames with overrun
        @(negedge clk);
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        run_phase(2);

        // Fill, then a fifth frame whose push coincides with an OVR clear
        @(negedge clk);
        for (int i = 1; i <= 4; i++) send_frame(8'(i * 16), 1'b1);
        fork
            send_frame(8'h50, 1'b1);
            begin
                repeat (96) @(negedge clk);
                apb_write(1'b1, 16'h0004);
            end
        join
        run_phase(3);

        // Framing error followed by a held-low line
        @(negedge clk);
        send_frame(8'h3C, 1'b0);
        repeat (30) @(negedge clk);
        rx_wire = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check("break_exit_state", {13'd0, rx_state}, 16'd0);
        run_phase(4);
        @(negedge clk);
        send_frame(8'h55, 1'b1);
        run_phase(5);

        // Three-clock glitch on the idle line
        @(negedge clk);
        rx_wire = 1'b0;
        repeat (3) @(negedge clk);
        rx_wire = 1'b1;
        #1;
        check("glitch_seen_start", {13'd0, rx_state}, 16'd1);
        repeat (20) @(negedge clk);
        #1;
        check("glitch_back_idle", {13'd0, rx_state}, 16'd0);
        run_phase(6);

        // Reset during DATA with one byte queued
        @(negedge clk);
        send_frame(8'h11, 1'b1);
        #1;
        check("pre_reset_irq", {15'd0, irq}, 16'd1);
        @(negedge clk);
        rx_wire = 1'b0;
        repeat (10) @(negedge clk);
        rx_wire = 1'b1;
        repeat (10) @(negedge clk);
        rx_wire = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("pre_reset_state_data", {13'd0, rx_state}, 16'd2);
        reset = 1'b0;
        rx_wire = 1'b1;
        #1;
        check("mid_reset_irq", {15'd0, irq}, 16'd0);
        check("mid_reset_state", {13'd0, rx_state}, 16'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        apb_read(1'b1, rd);
        check("post_reset_status", rd, 16'h0000);
        @(negedge clk);
        send_frame(8'h66, 1'b1);
        run_phase(7);

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
